// File: rtl/reg_to_obi_bridge.sv
// reg_to_obi_bridge: converts a simple valid/ready register-interface request
// into a single outstanding OBI transaction, with an optional per-transaction
// timeout that reports an error and then drains the orphaned OBI handshake.
module reg_to_obi_bridge #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        reg_valid_i,
    input  logic        reg_write_i,
    input  logic [31:0] reg_addr_i,
    input  logic [31:0] reg_wdata_i,
    input  logic [3:0]  reg_wstrb_i,
    output logic        reg_ready_o,
    output logic [31:0] reg_rdata_o,
    output logic        reg_error_o,
    output logic        obi_req_o,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_gnt_i,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R,
        ST_DONE,
        ST_FLUSH_G,
        ST_FLUSH_R
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [15:0] r_cnt;
    logic        r_err;
    logic        w_timeout;

    // Counter only ever climbs from zero, so ">=" fires on the first cycle
    // the limit is reached; it also catches the grant-on-limit corner case
    // where the count has already moved past the limit when WAIT_R starts.
    assign w_timeout = (TIMEOUT_CYCLES != 16'd0) && (r_cnt >= TIMEOUT_CYCLES);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; a completing handshake always beats the timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (reg_valid_i)  w_next = ST_REQ;
            ST_REQ: begin
                if (obi_gnt_i)            w_next = ST_WAIT_R;
                else if (w_timeout)       w_next = ST_FLUSH_G;
            end
            ST_WAIT_R: begin
                if (obi_rvalid_i)         w_next = ST_DONE;
                else if (w_timeout)       w_next = ST_FLUSH_R;
            end
            ST_DONE:                      w_next = ST_IDLE;
            ST_FLUSH_G: if (obi_gnt_i)    w_next = ST_FLUSH_R;
            ST_FLUSH_R: if (obi_rvalid_i) w_next = ST_IDLE;
            default:                      w_next = ST_IDLE;
        endcase
    end

    // Output decode; response fields are forced to zero outside the ready pulse
    always_comb begin
        obi_req_o   = (r_state == ST_REQ) || (r_state == ST_FLUSH_G);
        busy_o      = (r_state != ST_IDLE);
        reg_ready_o = (r_state == ST_DONE) || r_err;
        reg_error_o = r_err;
        reg_rdata_o = (r_state == ST_DONE) ? r_rdata : '0;
    end

    assign obi_addr_o  = r_addr;
    assign obi_we_o    = r_we;
    assign obi_be_o    = r_be;
    assign obi_wdata_o = r_wdata;

    // Request latch, timeout counter, response capture and error pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && reg_valid_i) begin
                r_addr  <= reg_addr_i & 32'hFFFF_FFFC;
                r_we    <= reg_write_i;
                r_be    <= reg_write_i ? reg_wstrb_i : 4'hF;
                r_wdata <= reg_write_i ? reg_wdata_i : '0;
                r_cnt   <= '0;
            end else if (((r_state == ST_REQ) || (r_state == ST_WAIT_R)) && (r_cnt != '1)) begin
                r_cnt   <= r_cnt + 16'd1;
            end

            if ((r_state == ST_WAIT_R) && obi_rvalid_i) begin
                r_rdata <= r_we ? '0 : obi_rdata_i;
            end

            // Error pulse lands in the first flush cycle
            r_err <= ((r_state == ST_REQ)    && (w_next == ST_FLUSH_G)) ||
                     ((r_state == ST_WAIT_R) && (w_next == ST_FLUSH_R));
        end
    end

endmodule

// File: tb/tb_reg_to_obi_bridge.sv
// Self-checking bench for reg_to_obi_bridge. Two instances (default timeout and
// TIMEOUT_CYCLES=4) run open-loop directed timelines; a transaction-level model
// turns each scenario into per-cycle expected outputs, checked every cycle.
module tb_reg_to_obi_bridge;

    localparam int NCYC = 60;

    logic clk;
    int   cyc;
    int   n_checks;
    int   n_err;

    // Per-instance DUT inputs
    logic        rst_i        [2];
    logic        reg_valid_i  [2];
    logic        reg_write_i  [2];
    logic [31:0] reg_addr_i   [2];
    logic [31:0] reg_wdata_i  [2];
    logic [3:0]  reg_wstrb_i  [2];
    logic        obi_gnt_i    [2];
    logic        obi_rvalid_i [2];
    logic [31:0] obi_rdata_i  [2];

    // Per-instance DUT outputs
    logic        reg_ready_o  [2];
    logic [31:0] reg_rdata_o  [2];
    logic        reg_error_o  [2];
    logic        obi_req_o    [2];
    logic [31:0] obi_addr_o   [2];
    logic        obi_we_o     [2];
    logic [3:0]  obi_be_o     [2];
    logic [31:0] obi_wdata_o  [2];
    logic        busy_o       [2];

    // Stimulus timeline
    logic        s_rst   [2][NCYC];
    logic        s_valid [2][NCYC];
    logic        s_write [2][NCYC];
    logic [31:0] s_addr  [2][NCYC];
    logic [31:0] s_wdata [2][NCYC];
    logic [3:0]  s_wstrb [2][NCYC];
    logic        s_gnt   [2][NCYC];
    logic        s_rv    [2][NCYC];
    logic [31:0] s_rdata [2][NCYC];

    // Expected outputs timeline
    logic        e_req   [2][NCYC];
    logic        e_busy  [2][NCYC];
    logic        e_ready [2][NCYC];
    logic        e_err   [2][NCYC];
    logic [31:0] e_rdata [2][NCYC];
    logic [31:0] e_addr  [2][NCYC];
    logic        e_we    [2][NCYC];
    logic [3:0]  e_be    [2][NCYC];
    logic [31:0] e_wdata [2][NCYC];

    reg_to_obi_bridge #(.TIMEOUT_CYCLES(16'd255)) dut0 (
        .clk_i(clk), .rst_i(rst_i[0]),
        .reg_valid_i(reg_valid_i[0]), .reg_write_i(reg_write_i[0]),
        .reg_addr_i(reg_addr_i[0]), .reg_wdata_i(reg_wdata_i[0]), .reg_wstrb_i(reg_wstrb_i[0]),
        .reg_ready_o(reg_ready_o[0]), .reg_rdata_o(reg_rdata_o[0]), .reg_error_o(reg_error_o[0]),
        .obi_req_o(obi_req_o[0]), .obi_addr_o(obi_addr_o[0]), .obi_we_o(obi_we_o[0]),
        .obi_be_o(obi_be_o[0]), .obi_wdata_o(obi_wdata_o[0]),
        .obi_gnt_i(obi_gnt_i[0]), .obi_rvalid_i(obi_rvalid_i[0]), .obi_rdata_i(obi_rdata_i[0]),
        .busy_o(busy_o[0])
    );

    reg_to_obi_bridge #(.TIMEOUT_CYCLES(16'd4)) dut1 (
        .clk_i(clk), .rst_i(rst_i[1]),
        .reg_valid_i(reg_valid_i[1]), .reg_write_i(reg_write_i[1]),
        .reg_addr_i(reg_addr_i[1]), .reg_wdata_i(reg_wdata_i[1]), .reg_wstrb_i(reg_wstrb_i[1]),
        .reg_ready_o(reg_ready_o[1]), .reg_rdata_o(reg_rdata_o[1]), .reg_error_o(reg_error_o[1]),
        .obi_req_o(obi_req_o[1]), .obi_addr_o(obi_addr_o[1]), .obi_we_o(obi_we_o[1]),
        .obi_be_o(obi_be_o[1]), .obi_wdata_o(obi_wdata_o[1]),
        .obi_gnt_i(obi_gnt_i[1]), .obi_rvalid_i(obi_rvalid_i[1]), .obi_rdata_i(obi_rdata_i[1]),
        .busy_o(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Transaction-level model: request accepted at s, first OBI request at s+1,
    // grant at g, response at r. Timeout fires when T cycles have elapsed since
    // s+1 without the pending handshake; the error pulse comes one cycle later
    // and the bridge then stays busy until the slave's response at r.
    function automatic void add_txn(input int i, input int T, input int s, input bit w,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    input logic [3:0] st, input int g, input int r,
                                    input logic [31:0] rd, input int rst_at);
        int q, tcyc, vend, bend, rdy;
        bit err;
        q    = s + 1;
        tcyc = (T != 0) ? q + T : 1000000;
        err  = 1'b0;
        rdy  = -1;
        if (rst_at >= 0) begin
            vend = rst_at;
            bend = rst_at;
            s_rst[i][rst_at] = 1'b1;
        end else if (tcyc < r) begin
            rdy  = tcyc + 1;
            err  = 1'b1;
            vend = rdy;
            bend = r;
        end else begin
            rdy  = r + 1;
            vend = rdy;
            bend = rdy;
        end
        for (int c = s; c <= vend; c++) begin
            s_valid[i][c] = 1'b1;
            s_write[i][c] = w;
            s_addr[i][c]  = a;
            s_wdata[i][c] = wd;
            s_wstrb[i][c] = st;
        end
        for (int c = q; c <= g; c++) begin
            e_req[i][c]   = 1'b1;
            e_addr[i][c]  = a & 32'hFFFF_FFFC;
            e_we[i][c]    = w;
            e_be[i][c]    = w ? st : 4'hF;
            e_wdata[i][c] = w ? wd : 32'h0;
        end
        for (int c = q; c <= bend; c++) e_busy[i][c] = 1'b1;
        if (rdy >= 0) begin
            e_ready[i][rdy] = 1'b1;
            e_err[i][rdy]   = err;
            e_rdata[i][rdy] = (err || w) ? 32'h0 : rd;
        end
        s_gnt[i][g]   = 1'b1;
        s_rv[i][r]    = 1'b1;
        s_rdata[i][r] = rd;
    endfunction

    task automatic apply(input int c);
        for (int i = 0; i < 2; i++) begin
            if (c >= 0 && c < NCYC) begin
                rst_i[i]        = s_rst[i][c];
                reg_valid_i[i]  = s_valid[i][c];
                reg_write_i[i]  = s_write[i][c];
                reg_addr_i[i]   = s_addr[i][c];
                reg_wdata_i[i]  = s_wdata[i][c];
                reg_wstrb_i[i]  = s_wstrb[i][c];
                obi_gnt_i[i]    = s_gnt[i][c];
                obi_rvalid_i[i] = s_rv[i][c];
                obi_rdata_i[i]  = s_rdata[i][c];
            end else begin
                rst_i[i]        = 1'b0;
                reg_valid_i[i]  = 1'b0;
                reg_write_i[i]  = 1'b0;
                reg_addr_i[i]   = 32'h0;
                reg_wdata_i[i]  = 32'h0;
                reg_wstrb_i[i]  = 4'h0;
                obi_gnt_i[i]    = 1'b0;
                obi_rvalid_i[i] = 1'b0;
                obi_rdata_i[i]  = 32'h0;
            end
        end
    endtask

    // Build timelines, then drive inputs 1 time unit after each rising edge
    initial begin
        cyc      = -1;
        n_checks = 0;
        n_err    = 0;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NCYC; c++) begin
                s_rst[i][c] = 1'b0;   s_valid[i][c] = 1'b0; s_write[i][c] = 1'b0;
                s_addr[i][c] = 32'h0; s_wdata[i][c] = 32'h0; s_wstrb[i][c] = 4'h0;
                s_gnt[i][c] = 1'b0;   s_rv[i][c] = 1'b0;    s_rdata[i][c] = 32'h0;
                e_req[i][c] = 1'b0;   e_busy[i][c] = 1'b0;  e_ready[i][c] = 1'b0;
                e_err[i][c] = 1'b0;   e_rdata[i][c] = 32'h0; e_addr[i][c] = 32'h0;
                e_we[i][c] = 1'b0;    e_be[i][c] = 4'h0;    e_wdata[i][c] = 32'h0;
            end
            for (int c = 0; c < 3; c++) s_rst[i][c] = 1'b1;
        end

        // Instance 0, default timeout
        add_txn(0, 255,  3, 1'b0, 32'h2000_0006, 32'h0,         4'h0, 4,  5,  32'hCAFE_F00D, -1);
        add_txn(0, 255, 10, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'h3, 16, 17, 32'h5555_5555, -1);
        s_rv[0][13] = 1'b1; s_rdata[0][13] = 32'hDEAD_BEEF;   // stray rvalid before grant
        add_txn(0, 255, 22, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 23, 24, 32'h1111_1111, -1);
        add_txn(0, 255, 26, 1'b0, 32'h0000_0044, 32'h0,         4'h0, 27, 28, 32'h2222_2222, -1);
        add_txn(0, 255, 32, 1'b0, 32'h0000_0080, 32'h0,         4'h0, 33, 37, 32'h7777_7777, 35);
        s_gnt[0][40] = 1'b1;                                  // stray grant while idle
        s_rv[0][41] = 1'b1; s_rdata[0][41] = 32'hFFFF_FFFF;   // stray rvalid while idle
        add_txn(0, 255, 44, 1'b0, 32'h0000_00C8, 32'h0,         4'h0, 47, 51, 32'h0F0F_0F0F, -1);

        // Instance 1, TIMEOUT_CYCLES=4
        add_txn(1, 4,  3, 1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 4'hF, 15, 17, 32'h9999_9999, -1);
        add_txn(1, 4, 22, 1'b0, 32'h0000_0500, 32'h0,         4'h0, 23, 27, 32'h0BAD_F00D, -1);
        add_txn(1, 4, 32, 1'b0, 32'h0000_0600, 32'h0,         4'h0, 33, 40, 32'h3333_3333, -1);
        s_valid[1][39] = 1'b1; s_addr[1][39] = 32'h0000_0900; // request during flush is not taken
        add_txn(1, 4, 43, 1'b0, 32'h0000_0700, 32'h0,         4'h0, 44, 45, 32'h4444_4444, -1);

        for (int i = 0; i < 2; i++) begin
            rst_i[i] = 1'b1; reg_valid_i[i] = 1'b0; reg_write_i[i] = 1'b0;
            reg_addr_i[i] = 32'h0; reg_wdata_i[i] = 32'h0; reg_wstrb_i[i] = 4'h0;
            obi_gnt_i[i] = 1'b0; obi_rvalid_i[i] = 1'b0; obi_rdata_i[i] = 32'h0;
        end

        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            apply(cyc);
        end
    end

    // Model comparison on every cycle, away from the rising edge
    always @(negedge clk) begin
        if (cyc >= 0 && cyc < NCYC) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d.ready", i), 32'(reg_ready_o[i]), 32'(e_ready[i][cyc]));
                chk($sformatf("u%0d.error", i), 32'(reg_error_o[i]), 32'(e_err[i][cyc]));
                chk($sformatf("u%0d.rdata", i), reg_rdata_o[i],      e_rdata[i][cyc]);
                chk($sformatf("u%0d.req", i),   32'(obi_req_o[i]),   32'(e_req[i][cyc]));
                chk($sformatf("u%0d.busy", i),  32'(busy_o[i]),      32'(e_busy[i][cyc]));
                if (e_req[i][cyc]) begin
                    chk($sformatf("u%0d.addr", i),  obi_addr_o[i],     e_addr[i][cyc]);
                    chk($sformatf("u%0d.we", i),    32'(obi_we_o[i]),  32'(e_we[i][cyc]));
                    chk($sformatf("u%0d.be", i),    32'(obi_be_o[i]),  32'(e_be[i][cyc]));
                    chk($sformatf("u%0d.wdata", i), obi_wdata_o[i],    e_wdata[i][cyc]);
                end
            end
        end
    end

    task automatic at_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Hand-computed literal expectations, then the summary
    initial begin
        at_cyc(0);
        chk("pin.rst_ready0", 32'(reg_ready_o[0]), 32'h0);
        chk("pin.rst_busy1",  32'(busy_o[1]),      32'h0);
        at_cyc(4);
        chk("pin.rd_req",   32'(obi_req_o[0]), 32'h1);
        chk("pin.rd_addr",  obi_addr_o[0],     32'h2000_0004);
        chk("pin.rd_be",    32'(obi_be_o[0]),  32'hF);
        chk("pin.rd_we",    32'(obi_we_o[0]),  32'h0);
        chk("pin.u1_req",   32'(obi_req_o[1]), 32'h1);
        at_cyc(6);
        chk("pin.rd_ready", 32'(reg_ready_o[0]), 32'h1);
        chk("pin.rd_rdata", reg_rdata_o[0],      32'hCAFE_F00D);
        chk("pin.rd_err",   32'(reg_error_o[0]), 32'h0);
        at_cyc(9);
        chk("pin.to_ready", 32'(reg_ready_o[1]), 32'h1);
        chk("pin.to_err",   32'(reg_error_o[1]), 32'h1);
        chk("pin.to_rdata", reg_rdata_o[1],      32'h0);
        chk("pin.to_req",   32'(obi_req_o[1]),   32'h1);
        at_cyc(11);
        chk("pin.wr_be",    32'(obi_be_o[0]),  32'h3);
        chk("pin.wr_wdata", obi_wdata_o[0],    32'h1234_5678);
        chk("pin.wr_we",    32'(obi_we_o[0]),  32'h1);
        at_cyc(12);
        chk("pin.flushg_req",  32'(obi_req_o[1]), 32'h1);
        chk("pin.flushg_busy", 32'(busy_o[1]),    32'h1);
        at_cyc(16);
        chk("pin.wr_req6",     32'(obi_req_o[0]), 32'h1);
        chk("pin.flushr_req",  32'(obi_req_o[1]), 32'h0);
        chk("pin.flushr_busy", 32'(busy_o[1]),    32'h1);
        at_cyc(17);
        chk("pin.wr_req_off", 32'(obi_req_o[0]), 32'h0);
        at_cyc(18);
        chk("pin.wr_ready",   32'(reg_ready_o[0]), 32'h1);
        chk("pin.wr_rdata",   reg_rdata_o[0],      32'h0);
        chk("pin.flush_idle", 32'(busy_o[1]),      32'h0);
        chk("pin.flush_noready", 32'(reg_ready_o[1]), 32'h0);
        at_cyc(23);
        chk("pin.b2b_req1", 32'(obi_req_o[0]), 32'h1);
        at_cyc(25);
        chk("pin.b2b_rdata1", reg_rdata_o[0], 32'h1111_1111);
        at_cyc(26);
        chk("pin.b2b_gap", 32'(obi_req_o[0]), 32'h0);
        at_cyc(27);
        chk("pin.b2b_req2", 32'(obi_req_o[0]), 32'h1);
        at_cyc(28);
        chk("pin.tie_ready", 32'(reg_ready_o[1]), 32'h1);
        chk("pin.tie_rdata", reg_rdata_o[1],      32'h0BAD_F00D);
        chk("pin.tie_err",   32'(reg_error_o[1]), 32'h0);
        at_cyc(29);
        chk("pin.b2b_rdata2", reg_rdata_o[0], 32'h2222_2222);
        at_cyc(36);
        chk("pin.rst_req",   32'(obi_req_o[0]),   32'h0);
        chk("pin.rst_busy",  32'(busy_o[0]),      32'h0);
        chk("pin.rst_ready", 32'(reg_ready_o[0]), 32'h0);
        at_cyc(38);
        chk("pin.late_rv_ignored", 32'(reg_ready_o[0]), 32'h0);
        chk("pin.wto_ready", 32'(reg_ready_o[1]), 32'h1);
        chk("pin.wto_err",   32'(reg_error_o[1]), 32'h1);
        at_cyc(NCYC);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_to_obi_bridge.md
REG_TO_OBI_BRIDGE -- requirements
Module: reg_to_obi_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd255, max OBI cycles per transaction before error; 0 disables timeout.
REQ-002 clk_i  in  1  system clock; all logic rising-edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 reg_valid_i  in  1  register-interface request valid; held with fields stable until reg_ready_o.
REQ-005 reg_write_i  in  1  1 = write, 0 = read.
REQ-006 reg_addr_i  in  32  byte address.
REQ-007 reg_wdata_i  in  32  write data.
REQ-008 reg_wstrb_i  in  4  write byte strobes.
REQ-009 reg_ready_o  out  1  one-cycle completion pulse; rdata/error valid same cycle.
REQ-010 reg_rdata_o  out  32  read data.
REQ-011 reg_error_o  out  1  transaction timed out.
REQ-012 obi_req_o  out  1  OBI master request.
REQ-013 obi_addr_o  out  32  OBI address.
REQ-014 obi_we_o  out  1  OBI write enable.
REQ-015 obi_be_o  out  4  OBI byte enables.
REQ-016 obi_wdata_o  out  32  OBI write data.
REQ-017 obi_gnt_i  in  1  OBI grant.
REQ-018 obi_rvalid_i  in  1  OBI response valid.
REQ-019 obi_rdata_i  in  32  OBI response data.
REQ-020 busy_o  out  1  high in any state except IDLE.

Function
REQ-021 FSM states IDLE, REQ, WAIT_R, DONE, FLUSH_G, FLUSH_R; one outstanding transaction maximum.
REQ-022 IDLE: on reg_valid_i=1 latch addr/write/wdata/wstrb, clear timeout counter, go REQ next cycle; no OBI activity in IDLE.
REQ-023 obi_addr_o = {latched addr[31:2], 2'b00}; obi_be_o = latched wstrb on write, 4'hF on read; obi_wdata_o = latched wdata on write, 0 on read; all driven from registers.
REQ-024 REQ: obi_req_o=1; on obi_gnt_i=1 go WAIT_R, obi_req_o low from next cycle; obi_req_o never deasserted before grant.
REQ-025 WAIT_R: on obi_rvalid_i=1 capture obi_rdata_i (reads only; writes capture 0), go DONE.
REQ-026 DONE: reg_ready_o=1 for exactly one cycle, reg_error_o=0, reg_rdata_o=captured data; go IDLE.
REQ-027 Minimum latency, gnt same cycle as req and rvalid next cycle: reg_valid_i at cycle 0 -> obi_req_o cycle 1 -> rvalid cycle 2 -> reg_ready_o cycle 3.
REQ-028 New request may be accepted in the IDLE cycle following DONE (back-to-back, one idle cycle between transactions).
REQ-029 Timeout counter (16 bit, saturating) increments every cycle in REQ and WAIT_R; when it equals TIMEOUT_CYCLES (nonzero) and the completing handshake is not present that cycle, next cycle pulse reg_ready_o=1, reg_error_o=1, reg_rdata_o=0.
REQ-030 After a timeout from REQ go FLUSH_G (obi_req_o held 1 until gnt, then FLUSH_R); from WAIT_R go FLUSH_R; FLUSH_R discards rdata on rvalid and returns to IDLE; no new request accepted while flushing.
REQ-031 Timeout and handshake in the same cycle: handshake wins, normal completion.
REQ-032 obi_rvalid_i outside WAIT_R/FLUSH_R and obi_gnt_i outside REQ/FLUSH_G are ignored.
REQ-033 reg_rdata_o and reg_error_o are 0 whenever reg_ready_o=0.

Reset
REQ-034 rst_i=1 at a clock edge forces IDLE, all outputs 0, counter and latched fields 0, regardless of state, including mid-transaction with obi_req_o high.
REQ-035 First request after reset release is accepted in the first cycle rst_i=0.

Verification
REQ-036 Read addr 0x2000_0006, gnt immediate, rvalid next cycle with 0xCAFE_F00D -> obi_addr 0x2000_0004, be 4'hF, we 0; reg_ready_o cycle 3 with rdata 0xCAFE_F00D, error 0.
REQ-037 Write 0x1234_5678 strobe 4'b0011, gnt delayed 5 cycles -> obi_req_o high 6 consecutive cycles, be 4'b0011, wdata 0x1234_5678, single ready pulse, rdata 0.
REQ-038 TIMEOUT_CYCLES=4, gnt never -> ready+error pulse with rdata 0, FSM in FLUSH_G with obi_req_o high; later gnt then rvalid -> IDLE, no second ready pulse.
REQ-039 Two back-to-back reads with zero-wait slave -> second obi_req_o exactly 4 cycles after first; each ready returns correct data.
REQ-040 rst_i asserted in WAIT_R -> next cycle obi_req_o=0, busy_o=0, no ready pulse; a late rvalid is ignored.
REQ-041 Timeout count reached in same cycle as rvalid -> normal completion, error 0, correct rdata.
